// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame DMA: default widths and the FSM state encoding.
package sobel_pkg;

   localparam int SOBEL_DATA_WIDTH = 8;
   localparam int SOBEL_ADDR_WIDTH = 12;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } dma_state_t;

endpackage

// File: rtl/sobel_skid_buffer.sv
// Two-entry FIFO that absorbs BRAM read latency so the output stream can stall without losing data.
module sobel_skid_buffer #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem0;
   logic [WIDTH-1:0] mem1;
   logic             wr_ptr;
   logic             rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != 2'd0);
   // A push into a full buffer is only legal when the head leaves in the same cycle.
   assign do_push = push && ((count != 2'd2) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem0   <= '0;
         mem1   <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            if (wr_ptr) mem1 <= push_data;
            else        mem0 <= push_data;
            wr_ptr <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign valid = (count != 2'd0);
   assign data  = rd_ptr ? mem1 : mem0;

endmodule

// File: rtl/sobel_frame_dma.sv
// Host-side initiator for the Sobel engine: loads a frame into BRAM b0, kicks the engine,
// waits for completion, then streams BRAM b1 back out through a skid buffer.
module sobel_frame_dma
   import sobel_pkg::*;
#(
   parameter int DATA_WIDTH = SOBEL_DATA_WIDTH,
   parameter int ADDR_WIDTH = SOBEL_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_num_cnt,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  eng_en,
   output logic                  eng_run,
   output logic [ADDR_WIDTH-1:0] eng_num_cnt,
   input  logic                  eng_idle,
   input  logic                  eng_done,
   output logic                  b0_ce0,
   output logic                  b0_we0,
   output logic [ADDR_WIDTH-1:0] b0_addr0,
   output logic [DATA_WIDTH-1:0] b0_d0,
   output logic                  b1_ce0,
   output logic                  b1_we0,
   output logic [ADDR_WIDTH-1:0] b1_addr0,
   output logic [DATA_WIDTH-1:0] b1_d0,
   input  logic [DATA_WIDTH-1:0] b1_q0,
   output dma_state_t            state_dbg
);

   // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
   // valid never waits on ready, and data/last are stable while valid is high and unaccepted.

   dma_state_t            state;
   dma_state_t            state_next;
   logic [ADDR_WIDTH-1:0] n_lat;
   logic [ADDR_WIDTH-1:0] wcnt;
   logic [ADDR_WIDTH-1:0] rcnt;
   logic                  inflight;
   logic                  inflight_last;
   logic                  start_ok;
   logic                  rd_issue;
   logic                  skid_pop;
   logic [1:0]            skid_count;
   logic                  skid_valid;
   logic [DATA_WIDTH:0]   skid_data;
   logic [2:0]            occ_after;

   assign start_ok = i_start && (i_num_cnt != '0);
   assign skid_pop = skid_valid && m_ready;

   // Occupancy after this cycle's pop; counting the pop keeps 1 pixel/cycle when never stalled.
   assign occ_after = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, skid_pop};
   assign rd_issue  = (state == ST_DRAIN) && (rcnt < n_lat) && (occ_after < 3'd2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start_ok) state_next = ST_LOAD;
         ST_LOAD:  if (s_valid && (wcnt == n_lat - 1'b1)) state_next = ST_RUN;
         ST_RUN:   if (eng_idle) state_next = ST_WAIT;
         ST_WAIT:  if (eng_done) state_next = ST_DRAIN;
         ST_DRAIN: if (skid_pop && skid_data[DATA_WIDTH]) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready  = 1'b0;
      b0_ce0   = 1'b0;
      b0_we0   = 1'b0;
      b0_addr0 = '0;
      b0_d0    = '0;
      b1_ce0   = 1'b0;
      b1_addr0 = '0;
      eng_run  = 1'b0;
      o_busy   = 1'b0;
      o_done   = 1'b0;
      case (state)
         ST_LOAD: begin
            o_busy  = 1'b1;
            s_ready = 1'b1;
            if (s_valid) begin
               b0_ce0   = 1'b1;
               b0_we0   = 1'b1;
               b0_addr0 = wcnt;
               b0_d0    = s_data;
            end
         end
         ST_RUN: begin
            o_busy  = 1'b1;
            eng_run = eng_idle;
         end
         ST_WAIT: begin
            o_busy = 1'b1;
         end
         ST_DRAIN: begin
            o_busy = 1'b1;
            if (rd_issue) begin
               b1_ce0   = 1'b1;
               b1_addr0 = rcnt;
            end
         end
         ST_DONE: begin
            o_busy = 1'b1;
            o_done = 1'b1;
         end
         default: begin
            o_busy = 1'b0;
         end
      endcase
   end

   // Frame length and address counters; the last-beat flag travels with the read in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_lat         <= '0;
         wcnt          <= '0;
         rcnt          <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && start_ok) begin
            n_lat <= i_num_cnt;
            wcnt  <= '0;
            rcnt  <= '0;
         end
         if (b0_ce0) begin
            wcnt <= wcnt + 1'b1;
         end
         if (rd_issue) begin
            rcnt <= rcnt + 1'b1;
         end
         inflight      <= rd_issue;
         inflight_last <= rd_issue && (rcnt == n_lat - 1'b1);
      end
   end

   sobel_skid_buffer #(
      .WIDTH(DATA_WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data ({inflight_last, b1_q0}),
      .pop       (m_ready),
      .valid     (skid_valid),
      .data      (skid_data),
      .count     (skid_count)
   );

   assign m_valid     = skid_valid;
   assign m_data      = skid_valid ? skid_data[DATA_WIDTH-1:0] : '0;
   assign m_last      = skid_valid && skid_data[DATA_WIDTH];
   assign eng_en      = o_busy;
   assign eng_num_cnt = n_lat;
   assign b1_we0      = 1'b0;
   assign b1_d0       = '0;
   assign state_dbg   = state;

endmodule

// File: tb/tb_sobel_frame_dma.sv
// Bench for sobel_frame_dma: BRAM and engine models, randomized frames, scoreboard on the output stream.
module tb_sobel_frame_dma;
   import sobel_pkg::*;

   localparam int DW = 8;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic [AW-1:0] i_num_cnt;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          o_busy;
   logic          o_done;
   logic          eng_en;
   logic          eng_run;
   logic [AW-1:0] eng_num_cnt;
   logic          eng_idle;
   logic          eng_done;
   logic          b0_ce0;
   logic          b0_we0;
   logic [AW-1:0] b0_addr0;
   logic [DW-1:0] b0_d0;
   logic          b1_ce0;
   logic          b1_we0;
   logic [AW-1:0] b1_addr0;
   logic [DW-1:0] b1_d0;
   logic [DW-1:0] b1_q0 = '0;
   dma_state_t    state_dbg;

   sobel_frame_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_num_cnt(i_num_cnt),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .o_busy(o_busy), .o_done(o_done), .eng_en(eng_en), .eng_run(eng_run),
      .eng_num_cnt(eng_num_cnt), .eng_idle(eng_idle), .eng_done(eng_done),
      .b0_ce0(b0_ce0), .b0_we0(b0_we0), .b0_addr0(b0_addr0), .b0_d0(b0_d0),
      .b1_ce0(b1_ce0), .b1_we0(b1_we0), .b1_addr0(b1_addr0), .b1_d0(b1_d0),
      .b1_q0(b1_q0), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- shared bench state ----------------
   int             checks = 0;
   int             errors = 0;
   logic [DW:0]    exp_q[$];
   logic [DW-1:0]  cur_pix [0:63];
   int             cur_n = 0;
   int             frame_id = 0;
   int             ready_mode = 0;
   int             eng_delay = 2;
   int             run_cnt = 0;
   int             done_cnt = 0;
   logic [DW-1:0]  b0_mem [0:(1<<AW)-1];
   logic [DW-1:0]  b1_mem [0:(1<<AW)-1];

   task automatic check_eq(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference transform the engine model applies per pixel.
   function automatic logic [DW-1:0] ref_pix(input logic [DW-1:0] p, input int i);
      logic [DW-1:0] t;
      t = p * 8'd3 + 8'(i);
      return t ^ 8'hA5;
   endfunction

   // ---------------- BRAM and engine models ----------------
   always @(posedge clk) begin
      if (b0_ce0 && b0_we0) b0_mem[b0_addr0] <= b0_d0;
      if (b1_ce0) b1_q0 <= b1_mem[b1_addr0];
   end

   initial begin
      eng_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && eng_run) begin
            for (int i = 0; i < int'(eng_num_cnt); i++) b1_mem[i] = ref_pix(b0_mem[i], i);
            repeat (eng_delay) @(posedge clk);
            #1 eng_done = 1'b1;
            @(posedge clk);
            #1 eng_done = 1'b0;
         end
      end
   end

   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int         mon_id = 0;
   int         wr_idx = 0;
   int         rd_idx = 0;
   int         issued = 0;
   int         accepted = 0;
   bit         first_seen = 0;
   int         drain_cyc = 0;
   int         first_cyc = 0;
   dma_state_t prev_state = ST_IDLE;

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_id != mon_id) begin
            mon_id = frame_id; wr_idx = 0; rd_idx = 0;
            issued = 0; accepted = 0; first_seen = 0;
         end
         if ((s_valid && s_ready) || b0_ce0) begin
            check_eq("b0_ce0_on_accept", b0_ce0, s_valid && s_ready);
            if (b0_ce0) begin
               check_eq("b0_we0", b0_we0, 1);
               check_eq("b0_addr0", b0_addr0, wr_idx);
               check_eq("b0_d0", b0_d0, cur_pix[wr_idx[5:0]]);
               wr_idx++;
            end
         end
         if (state_dbg == ST_RUN && prev_state != ST_RUN)
            check_eq("run_after_last_beat", wr_idx, cur_n);
         if (state_dbg == ST_DRAIN && prev_state != ST_DRAIN) drain_cyc = cyc;
         if (b1_ce0) begin
            check_eq("b1_we0", b1_we0, 0);
            check_eq("b1_addr0", b1_addr0, rd_idx);
            rd_idx++;
            issued++;
         end
         if (m_valid && !first_seen) begin
            first_seen = 1;
            first_cyc = cyc;
            if (ready_mode == 0) check_eq("drain_latency", cyc - drain_cyc, 2);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("m_beat_unexpected", {m_last, m_data}, -1);
            end else begin
               check_eq("m_beat", {m_last, m_data}, exp_q.pop_front());
            end
            accepted++;
            if (m_last && ready_mode == 0) check_eq("throughput", cyc - first_cyc, cur_n - 1);
         end
         if (b1_ce0 || m_valid) check_eq("skid_bound", (issued - accepted) <= 2, 1);
         if (eng_run) begin
            run_cnt++;
            check_eq("eng_run_idle", eng_idle, 1);
            check_eq("eng_num_cnt", eng_num_cnt, cur_n);
         end
         if (o_done) done_cnt++;
         prev_state = state_dbg;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_all_zero(input string tag);
      check_eq({tag, "_state"}, int'(state_dbg), int'(ST_IDLE));
      check_eq({tag, "_busy"}, o_busy, 0);
      check_eq({tag, "_en"}, eng_en, 0);
      check_eq({tag, "_run"}, eng_run, 0);
      check_eq({tag, "_done"}, o_done, 0);
      check_eq({tag, "_s_ready"}, s_ready, 0);
      check_eq({tag, "_m_valid"}, m_valid, 0);
      check_eq({tag, "_m_data"}, m_data, 0);
      check_eq({tag, "_m_last"}, m_last, 0);
      check_eq({tag, "_b0"}, {b0_ce0, b0_we0, b0_addr0, b0_d0}, 0);
      check_eq({tag, "_b1"}, {b1_ce0, b1_we0, b1_addr0, b1_d0}, 0);
   endtask

   task automatic start_frame(input int n);
      cur_n = n;
      frame_id++;
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), ref_pix(cur_pix[i], i)});
      i_num_cnt = AW'(n);
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      i_num_cnt = AW'($urandom_range(1, 4095));
   endtask

   task automatic load_pixels(input int n, input bit gap);
      int w;
      for (int i = 0; i < n; i++) begin
         if (gap) begin
            s_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
         end
         s_valid = 1'b1;
         s_data = cur_pix[i];
         w = 0;
         @(negedge clk);
         while (!s_ready && w < 100) begin
            @(negedge clk);
            w++;
         end
         if (!s_ready) check_eq("load_ready_timeout", 0, 1);
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_data = '0;
   endtask

   task automatic wait_done(input bit poke);
      bit got = 0;
      bit poked = 0;
      bit chk_next = 0;
      for (int c = 0; c < 3000 && !got; c++) begin
         @(negedge clk);
         if (o_done) begin
            got = 1;
         end else if (chk_next) begin
            chk_next = 0;
            check_eq("start_in_drain_n", eng_num_cnt, cur_n);
            check_eq("start_in_drain_busy", o_busy, 1);
         end else if (poke && !poked && state_dbg == ST_DRAIN) begin
            poked = 1;
            i_start = 1'b1;
            i_num_cnt = 12'd5;
            @(posedge clk);
            #1 i_start = 1'b0;
            chk_next = 1;
         end
      end
      check_eq("frame_done", got, 1);
      check_eq("scoreboard_drained", exp_q.size(), 0);
      @(negedge clk);
      check_eq("done_one_cycle", o_done, 0);
      check_eq("back_to_idle", int'(state_dbg), int'(ST_IDLE));
   endtask

   task automatic run_frame(input int n, input bit gap, input int rmode,
                            input bit eng_hold, input bit poke, input bit fixed_pix);
      int run0;
      int done0;
      run0 = run_cnt;
      done0 = done_cnt;
      ready_mode = rmode;
      eng_delay = $urandom_range(1, 5);
      if (!fixed_pix) for (int i = 0; i < n; i++) cur_pix[i] = 8'($urandom);
      if (eng_hold) eng_idle = 1'b0;
      start_frame(n);
      load_pixels(n, gap);
      if (eng_hold) begin
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_eq("run_hold_no_pulse", eng_run, 0);
         end
         check_eq("run_hold_state", int'(state_dbg), int'(ST_RUN));
         @(posedge clk);
         #1 eng_idle = 1'b1;
      end
      wait_done(poke);
      check_eq("one_eng_run", run_cnt - run0, 1);
      check_eq("one_o_done", done_cnt - done0, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      i_start = 1'b0;
      i_num_cnt = '0;
      s_valid = 1'b0;
      s_data = '0;
      eng_idle = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Fixed frame 10,20,30,40 with downstream always ready.
      cur_pix[0] = 8'd10; cur_pix[1] = 8'd20; cur_pix[2] = 8'd30; cur_pix[3] = 8'd40;
      run_frame(4, 0, 0, 0, 0, 1);
      // Back-pressure toggling every cycle.
      run_frame(16, 0, 1, 0, 0, 0);
      // Input gaps.
      run_frame(9, 1, 2, 0, 0, 0);
      // Engine not idle for 20 cycles in RUN.
      run_frame(5, 0, 0, 1, 0, 0);
      // Single-pixel frame.
      run_frame(1, 0, 0, 0, 0, 0);

      // Zero-length start is ignored.
      i_start = 1'b1;
      i_num_cnt = '0;
      @(posedge clk);
      #1 i_start = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check_eq("n0_ignored_state", int'(state_dbg), int'(ST_IDLE));
         check_eq("n0_ignored_busy", o_busy, 0);
      end
      @(posedge clk);
      #1;

      // Start during DRAIN is ignored.
      run_frame(16, 0, 2, 0, 1, 0);

      for (int f = 0; f < 4; f++) begin
         run_frame($urandom_range(1, 40), 1'($urandom_range(0, 1)), 2, 0, 0, 0);
      end

      // Reset in the middle of DRAIN, then a clean frame.
      ready_mode = 2;
      for (int i = 0; i < 16; i++) cur_pix[i] = 8'($urandom);
      start_frame(16);
      load_pixels(16, 0);
      for (int c = 0; c < 200 && state_dbg != ST_DRAIN; c++) @(negedge clk);
      check_eq("reached_drain", int'(state_dbg), int'(ST_DRAIN));
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_all_zero("mid_drain_reset");
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      run_frame(3, 0, 0, 0, 0, 0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
